// File: rtl/arb4_sched.sv
// Four-requester arbiter for a shared datapath slot: one-hot grant plus encoded id, hold timeout, break-before-make gap.
// Define ARB_RR_EN for round-robin selection; the default build is fixed priority 3>2>1>0.
module arb4_sched #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       pick_id;
    logic             owner_req;
    logic             hold_last;

`ifdef ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] idx;
    logic       found;

    // Search upward from rr_ptr; the 2-bit index wraps 3->0 on its own.
    always_comb begin
        pick_id = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                pick_id = idx;
                found   = 1'b1;
            end
        end
    end
`else
    always_comb begin
        if (req[3])      pick_id = 2'd3;
        else if (req[2]) pick_id = 2'd2;
        else if (req[1]) pick_id = 2'd1;
        else             pick_id = 2'd0;
    end
`endif

    assign owner_req = req[gnt_id];
    assign hold_last = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // A release by the owner or by enable takes precedence, so timeout only fires on a pure hold expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
`ifdef ARB_RR_EN
            rr_ptr    <= 2'd0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (req != 4'b0000)) begin
                        gnt       <= 4'b0001 << pick_id;
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req || !enable || hold_last) begin
                        gnt       <= 4'b0000;
                        gnt_id    <= 2'd0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        timeout   <= owner_req && enable;
                        state     <= TURN;
`ifdef ARB_RR_EN
                        rr_ptr    <= gnt_id + 2'd1;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb4_sched.sv
// Directed bench for arb4_sched: a vector table for the basic flow plus hand sequences for the hold-timeout corners.
module tb_arb4_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    arb4_sched #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       enable;
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        logic       exp_valid;
        logic       exp_timeout;
        string      name;
    } vec_t;

    vec_t vecs[18];

    // Drive inputs, clock once, and leave the sample point 1 time unit after the edge.
    task automatic apply_stimulus(input logic r, input logic en, input logic [3:0] rq);
        rst_n  = r;
        enable = en;
        req    = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [3:0] eg, input logic [1:0] ei,
                                input logic ev, input logic et);
        checks++;
        if (gnt !== eg || gnt_id !== ei || gnt_valid !== ev || timeout !== et) begin
            failures++;
            $display("[TB] FAIL %s: got gnt=%b id=%b valid=%b timeout=%b, want gnt=%b id=%b valid=%b timeout=%b",
                     name, gnt, gnt_id, gnt_valid, timeout, eg, ei, ev, et);
        end
    endtask

    // Grant requester 0 from idle, hold it through 15 more edges, then apply the final-edge inputs.
    task automatic run_hold(input string name, input logic last_en, input logic [3:0] last_req,
                            input logic exp_to);
        apply_stimulus(1'b1, 1'b1, 4'b0001);
        check_output({name, "_grant"}, 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) begin
            apply_stimulus(1'b1, 1'b1, 4'b0001);
            check_output({name, "_hold"}, 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        apply_stimulus(1'b1, last_en, last_req);
        check_output({name, "_drop"}, 4'b0000, 2'd0, 1'b0, exp_to);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "reset"};
        vecs[1]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "single_grant"};
        vecs[2]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "single_hold"};
        vecs[3]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "single_release"};
        vecs[4]  = '{1'b1, 1'b1, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0, "turn_gap"};
        vecs[5]  = '{1'b1, 1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0, "prio_top"};
        vecs[6]  = '{1'b1, 1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0, "prio_hold"};
        vecs[7]  = '{1'b1, 1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0, "prio_release"};
        vecs[8]  = '{1'b1, 1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0, "prio_turn"};
        vecs[9]  = '{1'b1, 1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, "prio_next"};
        vecs[10] = '{1'b1, 1'b1, 4'b0111, 4'b0010, 2'd1, 1'b1, 1'b0, "no_preempt"};
        vecs[11] = '{1'b1, 1'b0, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0, "enable_revoke"};
        vecs[12] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "disabled_turn"};
        vecs[13] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "disabled_idle"};
        vecs[14] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "disabled_idle2"};
        vecs[15] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "low_grant"};
        vecs[16] = '{1'b0, 1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_mid_grant"};
        vecs[17] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "regrant_after_reset"};

        rst_n  = 1'b0;
        enable = 1'b0;
        req    = 4'b0000;
        #12;
        check_output("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].enable, vecs[i].req);
            check_output(vecs[i].name, vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_valid, vecs[i].exp_timeout);
        end

        // Asynchronous clear between edges while granted.
        #2 rst_n = 1'b0;
        #1 check_output("reset_between_edges", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b1, 4'b0000);
        check_output("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Pure hold expiry: one-cycle timeout, TURN, then regrant while still requesting.
        run_hold("timeout", 1'b1, 4'b0001, 1'b1);
        apply_stimulus(1'b1, 1'b1, 4'b0001);
        check_output("timeout_pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'b0001);
        check_output("timeout_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'b0000);
        check_output("timeout_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'b0000);
        check_output("timeout_turn", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner drops on the expiry edge: normal release.
        run_hold("drop_at_expiry", 1'b1, 4'b0000, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'b0000);
        check_output("drop_turn", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Enable falls on the expiry edge: enable release.
        run_hold("disable_at_expiry", 1'b0, 4'b0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'b0001);
        check_output("disable_turn", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_RR_EN
        // Round-robin rotation with every owner releasing after two cycles.
        apply_stimulus(1'b1, 1'b1, 4'b1111);
        for (int n = 0; n < 5; n++) begin
            logic [1:0] id;
            id = 2'(n);
            check_output("rr_grant", 4'b0001 << id, id, 1'b1, 1'b0);
            apply_stimulus(1'b1, 1'b1, 4'b1111);
            apply_stimulus(1'b1, 1'b1, 4'b1111 & ~(4'b0001 << id));
            check_output("rr_release", 4'b0000, 2'd0, 1'b0, 1'b0);
            apply_stimulus(1'b1, 1'b1, 4'b1111);
            apply_stimulus(1'b1, 1'b1, 4'b1111);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
